// File: rtl/oup_ulpi_rx_fifo.sv
// Receive-byte FIFO between the ULPI sync-mode receive path and the packet layer.
// Optional occupancy/high-water outputs are enabled with `define OUP_RX_FIFO_LEVEL_EN.
module oup_ulpi_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                     ulpi_clk_i,
    input  logic                     rst_ni,
    input  logic [7:0]               wr_data_i,
    input  logic                     wr_en_i,
    output logic                     full_o,
    output logic                     almost_full_o,
    output logic [7:0]               rd_data_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    input  logic                     flush_i,
    output logic                     overflow_o,
    input  logic                     overflow_clr_i
`ifdef OUP_RX_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [$clog2(DEPTH):0]   peak_level_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_full;
    logic          w_valid;
    logic          w_wr_accept;
    logic          w_rd_accept;
    logic          w_overflow_set;
    logic [CW-1:0] w_count_nxt;

    assign w_full         = (r_count == CW'(DEPTH));
    assign w_valid        = (r_count != '0);
    assign w_wr_accept    = wr_en_i && !w_full;
    assign w_rd_accept    = w_valid && rd_ready_i;
    assign w_overflow_set = wr_en_i && w_full;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_accept && !w_rd_accept) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_rd_accept && !w_wr_accept) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ulpi_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_accept) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            // A new overflow wins over a same-cycle clear so no event is lost.
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are only observed behind rd_valid_o.
    always_ff @(posedge ulpi_clk_i) begin
        if (w_wr_accept && !flush_i) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    assign rd_data_o     = r_mem[r_rd_ptr];
    assign rd_valid_o    = w_valid;
    assign full_o        = w_full;
    assign almost_full_o = (r_count >= CW'(DEPTH - AFULL_MARGIN));
    assign overflow_o    = r_overflow;

`ifdef OUP_RX_FIFO_LEVEL_EN
    logic [CW-1:0] r_peak;

    always_ff @(posedge ulpi_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_peak <= '0;
        end else if (flush_i) begin
            r_peak <= '0;
        end else if (w_count_nxt > r_peak) begin
            r_peak <= w_count_nxt;
        end
    end

    assign level_o      = r_count;
    assign peak_level_o = r_peak;
`endif

endmodule
